// File: rtl/ncl_ripple_adder_stage.sv
// W-bit dual-rail (NCL) ripple-carry adder stage with a four-phase DATA/NULL
// completion handshake, modelled synchronously. Define NCL_ADDER_SUB_EN to add the sub port.
module ncl_ripple_adder_stage #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             init_n,
    input  logic [2*W-1:0]   A,
    input  logic [2*W-1:0]   B,
    input  logic [1:0]       carryin,
    output logic             ACOMP,
    output logic             BCOMP,
    output logic             carryinCOMP,
    output logic [2*W-1:0]   sum,
    input  logic             sumCOMP,
    output logic [1:0]       carryout,
    input  logic             carryCOMP,
    output logic             err,
    output logic [CNT_W-1:0] token_cnt
`ifdef NCL_ADDER_SUB_EN
    ,
    input  logic             sub
`endif
);

    typedef enum logic {
        S_NULL = 1'b0,
        S_DATA = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic           in_data, in_null, any_illegal;
    logic [W-1:0]   a_val, b_val;
    logic           cout_val;
    logic [2*W-1:0] sum_enc;
    logic           capture, do_release;

    // An ILLEGAL (11) pair fails both the one-hot and the all-zero test, so it
    // blocks every transition without needing a separate qualifier.
    always_comb begin
        in_data     = carryin[1] ^ carryin[0];
        in_null     = ~(carryin[1] | carryin[0]);
        any_illegal = carryin[1] & carryin[0];
        a_val       = '0;
        b_val       = '0;
        for (int i = 0; i < W; i++) begin
            in_data     = in_data & (A[2*i+1] ^ A[2*i]) & (B[2*i+1] ^ B[2*i]);
            in_null     = in_null & ~(A[2*i+1] | A[2*i]) & ~(B[2*i+1] | B[2*i]);
            any_illegal = any_illegal | (A[2*i+1] & A[2*i]) | (B[2*i+1] & B[2*i]);
            a_val[i]    = A[2*i+1];
`ifdef NCL_ADDER_SUB_EN
            b_val[i]    = sub ? B[2*i] : B[2*i+1];
`else
            b_val[i]    = B[2*i+1];
`endif
        end
    end

    // NOTE: blocking assignments here are deliberate: the carry must ripple
    // through the loop within one evaluation; only clocked state uses <=.
    always_comb begin
        logic c;
        logic s;
        c       = carryin[1];
        sum_enc = '0;
        for (int i = 0; i < W; i++) begin
            s            = a_val[i] ^ b_val[i] ^ c;
            c            = (a_val[i] & b_val[i]) | (c & (a_val[i] ^ b_val[i]));
            sum_enc[2*i+1] = s;
            sum_enc[2*i]   = ~s;
        end
        cout_val = c;
    end

    always_comb begin
        capture    = (state_q == S_NULL) && in_data && !sumCOMP && !carryCOMP;
        do_release = (state_q == S_DATA) && in_null && sumCOMP && carryCOMP;
        state_d    = state_q;
        if (capture) begin
            state_d = S_DATA;
        end else if (do_release) begin
            state_d = S_NULL;
        end
    end

    always_comb begin
        ACOMP       = (state_q == S_DATA);
        BCOMP       = ACOMP;
        carryinCOMP = ACOMP;
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q   <= S_NULL;
            sum       <= '0;
            carryout  <= '0;
            err       <= 1'b0;
            token_cnt <= '0;
        end else begin
            state_q <= state_d;
            err     <= err | any_illegal;
            if (capture) begin
                sum       <= sum_enc;
                carryout  <= {cout_val, ~cout_val};
                token_cnt <= token_cnt + CNT_W'(1);
            end else if (do_release) begin
                sum      <= '0;
                carryout <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ncl_ripple_adder_stage.sv
// Self-checking bench for ncl_ripple_adder_stage: directed cases plus random
// wavefronts against an arithmetic reference model (CNT_W = 4 to exercise wrap).
module tb_ncl_ripple_adder_stage;

    localparam int W     = 8;
    localparam int CNT_W = 4;

    logic              clk = 1'b0;
    logic              init_n;
    logic [2*W-1:0]    A, B, sum;
    logic [1:0]        carryin, carryout;
    logic              ACOMP, BCOMP, carryinCOMP;
    logic              sumCOMP, carryCOMP, err, sub;
    logic [CNT_W-1:0]  token_cnt;

    ncl_ripple_adder_stage #(.W(W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .init_n      (init_n),
        .A           (A),
        .B           (B),
        .carryin     (carryin),
        .ACOMP       (ACOMP),
        .BCOMP       (BCOMP),
        .carryinCOMP (carryinCOMP),
        .sum         (sum),
        .sumCOMP     (sumCOMP),
        .carryout    (carryout),
        .carryCOMP   (carryCOMP),
        .err         (err),
        .token_cnt   (token_cnt)
`ifdef NCL_ADDER_SUB_EN
        ,
        .sub         (sub)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: phase flag, expected outputs, counter kept as an int.
    bit          m_ph;
    logic [15:0] m_sum;
    logic [1:0]  m_cout;
    logic        m_err;
    int          m_cnt;

    function automatic logic [15:0] enc(input logic [7:0] v);
        logic [15:0] r;
        for (int i = 0; i < 8; i++) begin
            r[2*i+1] = v[i];
            r[2*i]   = ~v[i];
        end
        return r;
    endfunction

    function automatic logic [1:0] enc1(input logic v);
        return v ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [25:0] obs();
        return {ACOMP, BCOMP, carryinCOMP, carryout, sum, err, token_cnt};
    endfunction

    function automatic logic [25:0] expv();
        return {m_ph, m_ph, m_ph, m_cout, m_sum, m_err, 4'(m_cnt)};
    endfunction

    task automatic model_reset();
        m_ph = 0; m_sum = '0; m_cout = '0; m_err = 0; m_cnt = 0;
    endtask

    // Apply the handshake rules to the inputs present just before a clock edge.
    task automatic model_edge();
        int n_data = 0, n_null = 0, n_ill = 0;
        int av = 0, bv = 0, cv, r;
        logic [1:0] p;
        for (int i = 0; i < 17; i++) begin
            if (i < 8)       p = {A[2*i+1], A[2*i]};
            else if (i < 16) p = {B[2*(i-8)+1], B[2*(i-8)]};
            else             p = carryin;
            case (p)
                2'b00:   n_null++;
                2'b11:   n_ill++;
                default: n_data++;
            endcase
        end
        for (int i = 0; i < 8; i++) begin
            av += int'(A[2*i+1]) << i;
            bv += int'(B[2*i+1]) << i;
        end
        cv = int'(carryin[1]);
        if (n_ill > 0) m_err = 1;
        if (!m_ph && n_data == 17 && !sumCOMP && !carryCOMP) begin
            if (sub) bv = 255 - bv;
            r      = av + bv + cv;
            m_sum  = enc(r[7:0]);
            m_cout = enc1(r[8]);
            m_cnt  = (m_cnt + 1) % 16;
            m_ph   = 1;
        end else if (m_ph && n_null == 17 && sumCOMP && carryCOMP) begin
            m_sum  = '0;
            m_cout = '0;
            m_ph   = 0;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_data(input logic [7:0] a, input logic [7:0] b, input logic c);
        A = enc(a); B = enc(b); carryin = enc1(c);
    endtask

    task automatic drive_release();
        A = '0; B = '0; carryin = '0;
        sumCOMP = 1; carryCOMP = 1;
        tick();
        sumCOMP = 0; carryCOMP = 0;
    endtask

    task automatic test_reset();
        init_n = 0; A = '0; B = '0; carryin = '0;
        sumCOMP = 0; carryCOMP = 0; sub = 0;
        model_reset();
        #1;
        total++;
        if (obs() !== 26'h0) begin
            bad++; $display("FAIL reset_state got=%h want=%h", obs(), 26'h0);
        end
        @(negedge clk);
        init_n = 1;
    endtask

    task automatic test_add();
        drive_data(8'h5A, 8'h3C, 1'b0);
        tick();
        total++;
        if ({sum, carryout, ACOMP, token_cnt} !== {enc(8'h96), 2'b01, 1'b1, 4'd1}) begin
            bad++; $display("FAIL add_data got=%h want=%h", {sum, carryout, ACOMP, token_cnt},
                            {enc(8'h96), 2'b01, 1'b1, 4'd1});
        end
        drive_release();
        total++;
        if (obs() !== expv() || sum !== '0 || ACOMP !== 1'b0) begin
            bad++; $display("FAIL add_null got=%h want=%h", obs(), expv());
        end
    endtask

    task automatic test_overflow();
        drive_data(8'hFF, 8'h01, 1'b1);
        tick();
        total++;
        if ({sum, carryout} !== {enc(8'h01), 2'b10}) begin
            bad++; $display("FAIL overflow got=%h want=%h", {sum, carryout}, {enc(8'h01), 2'b10});
        end
        drive_release();
    endtask

    task automatic test_hysteresis();
        logic [7:0] a, b;
        a = 8'($urandom); b = 8'($urandom);
        drive_data(a, b, 1'b1);
        B[7:6] = 2'b00;
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if (obs() !== expv() || ACOMP !== 1'b0 || sum !== '0) begin
                bad++; $display("FAIL hyst_partial got=%h want=%h", obs(), expv());
            end
        end
        B[7:6] = enc1(b[3]);
        tick();
        total++;
        if (obs() !== expv() || ACOMP !== 1'b1) begin
            bad++; $display("FAIL hyst_complete got=%h want=%h", obs(), expv());
        end
        drive_release();
        drive_data(a, b, 1'b0);
        sumCOMP = 1; carryCOMP = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if (obs() !== expv() || ACOMP !== 1'b0) begin
                bad++; $display("FAIL hyst_comp_split got=%h want=%h", obs(), expv());
            end
        end
        sumCOMP = 0;
        tick();
        total++;
        if (obs() !== expv() || ACOMP !== 1'b1) begin
            bad++; $display("FAIL hyst_comp_agree got=%h want=%h", obs(), expv());
        end
        drive_release();
    endtask

    task automatic test_illegal();
        drive_data(8'h12, 8'h34, 1'b0);
        A[1:0] = 2'b11;
        tick();
        total++;
        if (obs() !== expv() || err !== 1'b1 || ACOMP !== 1'b0) begin
            bad++; $display("FAIL illegal_set got=%h want=%h", obs(), expv());
        end
        A = '0; B = '0; carryin = '0;
        tick();
        total++;
        if (obs() !== expv() || err !== 1'b1) begin
            bad++; $display("FAIL illegal_sticky got=%h want=%h", obs(), expv());
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 24; n++) begin
            drive_data(8'($urandom), 8'($urandom), 1'($urandom));
`ifdef NCL_ADDER_SUB_EN
            sub = 1'($urandom);
`endif
            tick();
            sub = 0;
            total++;
            if (obs() !== expv()) begin
                bad++; $display("FAIL rand_data n=%0d got=%h want=%h", n, obs(), expv());
            end
            if ($urandom_range(0, 2) == 0) begin
                sumCOMP = 1'($urandom); carryCOMP = 1'($urandom);
                tick();
                total++;
                if (obs() !== expv()) begin
                    bad++; $display("FAIL rand_hold n=%0d got=%h want=%h", n, obs(), expv());
                end
            end
            drive_release();
            total++;
            if (obs() !== expv()) begin
                bad++; $display("FAIL rand_null n=%0d got=%h want=%h", n, obs(), expv());
            end
        end
    endtask

    task automatic test_wrap();
        int c0;
        c0 = m_cnt;
        for (int n = 0; n < 16; n++) begin
            drive_data(8'(n), 8'(3 * n), 1'b0);
            tick();
            drive_release();
        end
        total++;
        if (token_cnt !== 4'(c0) || obs() !== expv()) begin
            bad++; $display("FAIL wrap got=%0d want=%0d", token_cnt, c0);
        end
    endtask

    task automatic test_reset_mid();
        drive_data(8'hA5, 8'h5A, 1'b1);
        tick();
        total++;
        if (obs() !== expv() || ACOMP !== 1'b1 || err !== 1'b1) begin
            bad++; $display("FAIL pre_reset got=%h want=%h", obs(), expv());
        end
        #2;
        init_n = 0;
        #1;
        total++;
        if (obs() !== 26'h0) begin
            bad++; $display("FAIL reset_mid got=%h want=%h", obs(), 26'h0);
        end
        model_reset();
        A = '0; B = '0; carryin = '0;
        @(negedge clk);
        init_n = 1;
    endtask

`ifdef NCL_ADDER_SUB_EN
    task automatic test_sub();
        sub = 1;
        drive_data(8'h10, 8'h01, 1'b1);
        tick();
        sub = 0;
        total++;
        if ({sum, carryout} !== {enc(8'h0F), 2'b10}) begin
            bad++; $display("FAIL sub_pos got=%h want=%h", {sum, carryout}, {enc(8'h0F), 2'b10});
        end
        drive_release();
        sub = 1;
        drive_data(8'h00, 8'h01, 1'b1);
        tick();
        sub = 0;
        total++;
        if ({sum, carryout} !== {enc(8'hFF), 2'b01}) begin
            bad++; $display("FAIL sub_neg got=%h want=%h", {sum, carryout}, {enc(8'hFF), 2'b01});
        end
        drive_release();
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_overflow();
        test_hysteresis();
`ifdef NCL_ADDER_SUB_EN
        test_sub();
`endif
        test_back_to_back();
        test_wrap();
        test_illegal();
        test_reset_mid();
        test_add();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
